// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: owns the PC, fetches over req/gnt/rvalid, buffers words for decode
module fetch_stage #(
  parameter int                P_XLEN     = 32,
  parameter logic [P_XLEN-1:0] P_RESET_PC = '0
) (
  input  logic              iclk,
  input  logic              irst_n,
  output logic              oimem_req,
  output logic [P_XLEN-1:0] oimem_addr,
  input  logic              iimem_gnt,
  input  logic              iimem_rvalid,
  input  logic [P_XLEN-1:0] iimem_rdata,
  input  logic              iredirect,
  input  logic [P_XLEN-1:0] iredirect_pc,
  input  logic              iid_ready,
  output logic              oid_valid,
  output logic [P_XLEN-1:0] oid_instr,
  output logic [P_XLEN-1:0] oid_pc,
  output logic [P_XLEN-1:0] oid_pc4
);

  localparam logic [0:0]        S_REQ      = 1'b0;
  localparam logic [0:0]        S_WAIT     = 1'b1;
  localparam logic [P_XLEN-1:0] WORD       = P_XLEN'(4);
  localparam logic [P_XLEN-1:0] ALIGN_MASK = ~P_XLEN'(3);
  localparam logic [P_XLEN-1:0] RESET_PC   = P_RESET_PC & ALIGN_MASK;

  logic [0:0]        state;
  logic [P_XLEN-1:0] pc;
  logic              drop;
  logic              skid_valid;
  logic [P_XLEN-1:0] skid_instr;
  logic [P_XLEN-1:0] skid_pc;

  logic              handshake;
  logic              accept;
  logic              xfer;
  logic [P_XLEN-1:0] redirect_target;

  // No new request while the skid holds a word: the single outstanding
  // response must always have a free slot to land in.
  assign oimem_req       = irst_n & (state == S_REQ) & ~skid_valid;
  assign oimem_addr      = pc;
  assign handshake       = oimem_req & iimem_gnt;
  assign accept          = (state == S_WAIT) & iimem_rvalid & ~drop & ~iredirect;
  assign xfer            = oid_valid & iid_ready;
  assign redirect_target = iredirect_pc & ALIGN_MASK;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state <= S_REQ;
      pc    <= RESET_PC;
      drop  <= 1'b0;
    end else if (iredirect) begin
      pc <= redirect_target;
      if (((state == S_WAIT) && !iimem_rvalid) || handshake) begin
        drop  <= 1'b1;
        state <= S_WAIT;
      end else begin
        drop  <= 1'b0;
        state <= S_REQ;
      end
    end else begin
      case (state)
        S_REQ: begin
          if (handshake) state <= S_WAIT;
        end
        default: begin
          if (iimem_rvalid) begin
            state <= S_REQ;
            drop  <= 1'b0;
            if (!drop) pc <= pc + WORD;
          end
        end
      endcase
    end
  end

  // Output register plus one skid entry; the skid always drains first so order holds.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      oid_valid  <= 1'b0;
      oid_instr  <= '0;
      oid_pc     <= '0;
      oid_pc4    <= '0;
      skid_valid <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else if (iredirect) begin
      oid_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (xfer) begin
      if (skid_valid) begin
        oid_instr  <= skid_instr;
        oid_pc     <= skid_pc;
        oid_pc4    <= skid_pc + WORD;
        skid_valid <= accept;
        if (accept) begin
          skid_instr <= iimem_rdata;
          skid_pc    <= pc;
        end
      end else if (accept) begin
        oid_instr <= iimem_rdata;
        oid_pc    <= pc;
        oid_pc4   <= pc + WORD;
      end else begin
        oid_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!oid_valid) begin
        oid_valid <= 1'b1;
        oid_instr <= iimem_rdata;
        oid_pc    <= pc;
        oid_pc4   <= pc + WORD;
      end else begin
        skid_valid <= 1'b1;
        skid_instr <= iimem_rdata;
        skid_pc    <= pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with a behavioural memory and PC-stream model
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        iclk = 1'b0;
  logic        irst_n;
  logic        oimem_req;
  logic [31:0] oimem_addr;
  logic        iimem_gnt;
  logic        iimem_rvalid;
  logic [31:0] iimem_rdata;
  logic        iredirect;
  logic [31:0] iredirect_pc;
  logic        iid_ready;
  logic        oid_valid;
  logic [31:0] oid_instr;
  logic [31:0] oid_pc;
  logic [31:0] oid_pc4;

  int checks     = 0;
  int failures   = 0;
  int xfer_count = 0;

  bit          mem_fixed     = 1'b1;
  int          mem_lat_fixed = 0;
  bit          mem_busy      = 1'b0;
  logic [31:0] mem_addr;
  int          mem_lat;

  logic [31:0] exp_q[$];

  fetch_stage #(.P_XLEN(32), .P_RESET_PC(RST_PC)) dut (
    .iclk         (iclk),
    .irst_n       (irst_n),
    .oimem_req    (oimem_req),
    .oimem_addr   (oimem_addr),
    .iimem_gnt    (iimem_gnt),
    .iimem_rvalid (iimem_rvalid),
    .iimem_rdata  (iimem_rdata),
    .iredirect    (iredirect),
    .iredirect_pc (iredirect_pc),
    .iid_ready    (iid_ready),
    .oid_valid    (oid_valid),
    .oid_instr    (oid_instr),
    .oid_pc       (oid_pc),
    .oid_pc4      (oid_pc4)
  );

  always #5 iclk = ~iclk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Expected decode stream: sequential word PCs from the latest reset or redirect target.
  task automatic refill(input logic [31:0] base);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  task automatic step();
    @(negedge iclk);
    #3;
  endtask

  // Instruction memory: one outstanding request, in-order data, latency after grant.
  initial begin
    iimem_gnt    = 1'b0;
    iimem_rvalid = 1'b0;
    iimem_rdata  = '0;
    forever begin
      @(negedge iclk);
      iimem_rvalid = 1'b0;
      iimem_rdata  = $urandom;
      if (!irst_n) begin
        mem_busy = 1'b0;
      end else if (mem_busy) begin
        if (mem_lat == 0) begin
          iimem_rvalid = 1'b1;
          iimem_rdata  = mem_word(mem_addr);
          mem_busy     = 1'b0;
        end else begin
          mem_lat--;
        end
      end
      iimem_gnt = mem_fixed ? 1'b1 : ($urandom_range(3) != 0);
      #1;
      if (irst_n && oimem_req && iimem_gnt) begin
        mem_busy = 1'b1;
        mem_addr = oimem_addr;
        mem_lat  = mem_fixed ? mem_lat_fixed : int'($urandom_range(3));
      end
    end
  end

  // Monitor: pops the expected stream on every decode transfer.
  initial begin
    logic [31:0] e;
    bit          hold;
    logic [31:0] h_instr, h_pc, h_pc4;
    hold = 1'b0;
    h_instr = '0; h_pc = '0; h_pc4 = '0;
    refill(RST_PC);
    forever begin
      @(negedge iclk);
      #4;
      if (!irst_n) begin
        refill(RST_PC);
        hold = 1'b0;
        continue;
      end
      if (hold) begin
        chk("stall_instr", oid_instr, h_instr);
        chk("stall_pc", oid_pc, h_pc);
        chk("stall_pc4", oid_pc4, h_pc4);
      end
      if (oimem_req) chk("addr_align", {30'd0, oimem_addr[1:0]}, 32'd0);
      if (iredirect) begin
        refill(iredirect_pc & 32'hFFFF_FFFC);
        hold = 1'b0;
      end else begin
        if (oid_valid && iid_ready) begin
          e = exp_q.pop_front();
          exp_q.push_back(exp_q[$] + 32'd4);
          chk("xfer_pc", oid_pc, e);
          chk("xfer_instr", oid_instr, mem_word(e));
          chk("xfer_pc4", oid_pc4, e + 32'd4);
          xfer_count++;
        end
        hold    = oid_valid && !iid_ready;
        h_instr = oid_instr;
        h_pc    = oid_pc;
        h_pc4   = oid_pc4;
      end
    end
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int          t0;
    logic [31:0] hold_pc;
    irst_n       = 1'b0;
    iredirect    = 1'b0;
    iredirect_pc = '0;
    iid_ready    = 1'b1;

    repeat (3) step();
    chk("rst_valid", 32'(oid_valid), 32'd0);
    chk("rst_instr", oid_instr, 32'd0);
    chk("rst_pc", oid_pc, 32'd0);
    chk("rst_pc4", oid_pc4, 32'd0);
    chk("rst_req", 32'(oimem_req), 32'd0);
    chk("rst_addr", oimem_addr, RST_PC);

    // Free-running fetch: gnt always, data one cycle after grant.
    @(negedge iclk);
    irst_n = 1'b1;
    #3;
    chk("first_req", 32'(oimem_req), 32'd1);
    chk("first_addr", oimem_addr, RST_PC);
    chk("first_valid", 32'(oid_valid), 32'd0);
    step();
    chk("wait_valid", 32'(oid_valid), 32'd0);
    chk("wait_req", 32'(oimem_req), 32'd0);
    step();
    chk("lat_valid", 32'(oid_valid), 32'd1);
    chk("lat_pc", oid_pc, RST_PC);
    chk("lat_pc4", oid_pc4, RST_PC + 32'd4);
    chk("lat_instr", oid_instr, mem_word(RST_PC));
    chk("second_addr", oimem_addr, RST_PC + 32'd4);
    t0 = xfer_count;
    repeat (20) @(negedge iclk);
    #3;
    chk("throughput", 32'(xfer_count - t0), 32'd10);

    // Decode stall: second word lands in the skid, fetching stops.
    for (int n = 0; n < 20 && !oid_valid; n++) step();
    iid_ready = 1'b0;
    hold_pc   = oid_pc;
    repeat (6) step();
    chk("skid_req", 32'(oimem_req), 32'd0);
    chk("skid_valid", 32'(oid_valid), 32'd1);
    chk("skid_hold_pc", oid_pc, hold_pc);
    iid_ready = 1'b1;
    repeat (10) step();

    // Redirect the cycle after a grant, data two cycles after grant.
    mem_lat_fixed = 1;
    for (int n = 0; n < 20 && !(oimem_req && iimem_gnt); n++) step();
    @(negedge iclk);
    iredirect    = 1'b1;
    iredirect_pc = 32'h0000_0203;
    @(negedge iclk);
    iredirect = 1'b0;
    #3;
    for (int n = 0; n < 20 && !oimem_req; n++) step();
    chk("redir_addr", oimem_addr, 32'h0000_0200);
    for (int n = 0; n < 20 && !oid_valid; n++) step();
    chk("redir_pc", oid_pc, 32'h0000_0200);

    // Redirect coinciding with rvalid while decode is ready.
    mem_lat_fixed = 0;
    repeat (4) step();
    for (int n = 0; n < 20 && !(oid_valid && oimem_req); n++) step();
    iid_ready = 1'b0;
    step();
    chk("coin_setup", 32'(oid_valid && iimem_rvalid), 32'd1);
    iid_ready    = 1'b1;
    iredirect    = 1'b1;
    iredirect_pc = 32'h0000_0400;
    @(negedge iclk);
    iredirect = 1'b0;
    #3;
    chk("coin_valid", 32'(oid_valid), 32'd0);
    chk("coin_req", 32'(oimem_req), 32'd1);
    chk("coin_addr", oimem_addr, 32'h0000_0400);
    repeat (6) step();

    // PC wrap at the top of the address space.
    @(negedge iclk);
    iredirect    = 1'b1;
    iredirect_pc = 32'hFFFF_FFF8;
    @(negedge iclk);
    iredirect = 1'b0;
    #3;
    for (int n = 0; n < 40 && !(oid_valid && oid_pc == 32'hFFFF_FFFC); n++) step();
    chk("wrap_pc", oid_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", oid_pc4, 32'd0);
    for (int n = 0; n < 20 && !(oimem_req && oimem_addr == 32'd0); n++) step();
    chk("wrap_req", 32'(oimem_req), 32'd1);
    chk("wrap_addr", oimem_addr, 32'd0);
    repeat (6) step();

    // Randomised traffic: grants, latencies, decode stalls and redirects.
    mem_fixed = 1'b0;
    t0 = xfer_count;
    for (int i = 0; i < 3000; i++) begin
      @(negedge iclk);
      iid_ready    = ($urandom_range(3) != 0);
      iredirect    = ($urandom_range(23) == 0);
      iredirect_pc = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(15)) : $urandom;
    end
    @(negedge iclk);
    iredirect = 1'b0;
    #3;
    chk("random_progress", 32'(xfer_count - t0 > 200), 32'd1);

    // Asynchronous reset while a fetch is outstanding and decode holds a word.
    mem_fixed     = 1'b1;
    mem_lat_fixed = 2;
    iid_ready     = 1'b0;
    for (int n = 0; n < 40 && !(oid_valid && mem_busy && !oimem_req); n++) step();
    chk("arst_setup", 32'(oid_valid && mem_busy && !oimem_req), 32'd1);
    irst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(oid_valid), 32'd0);
    chk("arst_instr", oid_instr, 32'd0);
    chk("arst_pc", oid_pc, 32'd0);
    chk("arst_pc4", oid_pc4, 32'd0);
    chk("arst_req", 32'(oimem_req), 32'd0);
    chk("arst_addr", oimem_addr, RST_PC);
    @(negedge iclk);
    @(negedge iclk);
    irst_n    = 1'b1;
    iid_ready = 1'b1;
    #3;
    chk("rerun_req", 32'(oimem_req), 32'd1);
    chk("rerun_addr", oimem_addr, RST_PC);
    t0 = xfer_count;
    repeat (30) step();
    chk("rerun_progress", 32'(xfer_count - t0 > 3), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage directly upstream of the decode/control logic.
- Owns the PC and issues word fetches to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned instructions and presents them with their PC to decode under a valid/ready handshake; decode consumes instr[6:0] as the opcode.
- Accepts a redirect from execute for taken branches, jal, and jalr, and discards wrong-path fetches.

Parameters:
P_XLEN, 32, datapath/address width
P_RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)

Ports:
iclk  input  1  clock, rising edge
irst_n  input  1  asynchronous active-low reset
oimem_req  output  1  fetch request valid
oimem_addr  output  P_XLEN  fetch address (always word aligned)
iimem_gnt  input  1  memory accepts request this cycle (req & gnt = handshake)
iimem_rvalid  input  1  read data valid, exactly one per granted request, in order
iimem_rdata  input  P_XLEN  fetched instruction word
iredirect  input  1  change control flow this cycle
iredirect_pc  input  P_XLEN  redirect target
iid_ready  input  1  decode can accept the instruction this cycle
oid_valid  output  1  instruction held for decode is valid
oid_instr  output  P_XLEN  instruction word to decode
oid_pc  output  P_XLEN  PC of oid_instr
oid_pc4  output  P_XLEN  oid_pc + 4 (modulo 2^P_XLEN)

Behaviour:
- Clock and reset: one clock (iclk); reset (irst_n) is asynchronous and active-low.
- Reset values: pc=P_RESET_PC, state=S_REQ, drop=0, skid empty. All outputs are 0, with oimem_addr=P_RESET_PC and oimem_req=0. While irst_n=0, oimem_req=0 regardless of state.
- Outstanding fetches: at most one. Buffering is a 2-entry chain: the output register (oid_*) plus a 1-entry skid.
- oimem_addr always equals pc, with pc[1:0] always 2'b00.
- FSM, S_REQ:
  - oimem_req=1 iff the skid is empty.
  - On req&gnt -> S_WAIT.
  - The address may change before gnt only because of a redirect.
- FSM, S_WAIT:
  - oimem_req=0.
  - On rvalid & !drop: the word is accepted, pc<=pc+4, -> S_REQ.
  - On rvalid & drop: the word is discarded, drop<=0, pc unchanged, -> S_REQ.
- Accepted word placement:
  - If the output register is empty or being consumed (!oid_valid | iid_ready), the word goes to the output register.
  - Otherwise it goes to the skid.
  - The stored PC is the pc that was fetched.
- Decode handshake:
  - Transfer occurs on oid_valid & iid_ready.
  - On transfer, the output register reloads from the skid if the skid is full, otherwise from an accepted rvalid that cycle, otherwise it clears oid_valid.
  - Order is always preserved.
- oid_* is stable while oid_valid & !iid_ready.
- Latency: gnt in cycle n, rvalid earliest n+1, oid_valid earliest n+2 (registered).
- Redirect (highest priority):
  - pc<=iredirect_pc with bits [1:0] forced to 0.
  - oid_valid<=0 and the skid is cleared, even if iid_ready is high that cycle; the transfer is void.
  - If a request is outstanding after this cycle (state S_WAIT without rvalid, or S_REQ with gnt this cycle), drop<=1 and state=S_WAIT. Otherwise state=S_REQ.
  - Redirect coinciding with rvalid: that word is discarded.
  - Back-to-back redirects: the last target wins; drop stays 1 until the single outstanding response returns.
- PC arithmetic is modulo 2^P_XLEN: pc=32'hFFFF_FFFC, +4 -> 32'h0000_0000; oid_pc4 wraps identically.
- Reset mid-operation discards any outstanding response. Memory must also be reset; after reset release, rvalid is ignored unless a request is outstanding.
- No instruction decoding is done here; illegal opcodes pass through unchanged.

Test Plan:
- Reset P_RESET_PC=32'h100, gnt=1, rvalid one cycle after gnt, iid_ready=1 -> oimem_addr 100,104,108,...; oid_pc 100,104,... each with oid_pc4=oid_pc+4; one instruction per 2 cycles; oid_valid=0 before the first return.
- Hold iid_ready=0 for 6 cycles after the first instruction -> second word captured in the skid; oimem_req=0 while the skid is full; oid_instr/oid_pc unchanged. Release -> words emerge in order with no loss or duplication.
- Redirect to 32'h203 in the cycle after a gnt at addr 108, rvalid 2 cycles later -> the 108 word is discarded, next oimem_addr=32'h200, next oid_pc=32'h200.
- Redirect to 32'h400 coincident with rvalid and with iid_ready=1 while oid_valid=1 -> no transfer counted, the rvalid word is discarded, oid_valid=0 next cycle, fetch resumes at 32'h400.
- P_RESET_PC=32'hFFFF_FFF8, free-running -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; oid_pc4 of FFFF_FFFC = 0.
- Assert irst_n=0 mid S_WAIT with oid_valid=1 -> outputs clear asynchronously; after release, fetch restarts at P_RESET_PC.
